tx_rd_req_tlp_gen: RTL
======================

TX_RD_REQ_TLP_GEN -- requirements
Module: tx_rd_req_tlp_gen

Interface
REQ-001 SHALL provide parameter: TAG_BITS, 5, width of the rolling request tag (1..8).
REQ-002 SHALL provide ports, one per line, as follows:
- trn_clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- read_chunk  in  1  level request; fetch 512 B from host memory.
- huge_page_addr_read_from  in  64  host byte address of the chunk; stable while read_chunk is high.
- read_chunk_ack  out  1  one-cycle pulse; all read TLPs for the chunk have been sent.
- tx_req  out  1  request for the shared TRN TX interface.
- tx_grant  in  1  TX interface granted.
- trn_td  out  64  TX data.
- trn_trem_n  out  8  TX remainder.
- trn_tsof_n  out  1  start of TLP, active-low.
- trn_teof_n  out  1  end of TLP, active-low.
- trn_tsrc_rdy_n  out  1  source ready, active-low.
- trn_tsrc_dsc_n  out  1  source discontinue; constant 1.
- trn_tdst_rdy_n  in  1  destination ready, active-low.
- trn_tbuf_av  in  4  core buffer availability; bit 1 is non-posted.
- cfg_completer_id  in  16  requester ID {bus, dev, func}.
- cfg_dcommand  in  16  device control; [14:12] is the max read request size (MRRS).

Function
REQ-003 SHALL implement FSM states IDLE, ARB, HDR1, HDR2, NEXT, ACK.
REQ-004 IDLE: on read_chunk=1 and no ACK pending:
- latch addr = huge_page_addr_read_from;
- latch seg_len from MRRS: 000 -> 32 DW; 001 -> 64 DW; any other value -> 128 DW;
- set segs_left = 512 / (seg_len*4);
- go to ARB.
REQ-005 ARB: assert tx_req; on tx_grant=1 and trn_tbuf_av[1]=1, go to HDR1 with tsrc_rdy_n=0 and tsof_n=0.
REQ-006 HDR1 beat, trn_td, SHALL be:
- [63:32] = {1'b0, 7'b0100000, 1'b0, 3'b000, 4'b0, 1'b0, 1'b0, 2'b00, 2'b00, seg_len[9:0]};
- [31:0] = {cfg_completer_id, tag zero-extended to 8 bits, 4'hF, 4'hF}.
REQ-007 HDR2 beat SHALL be trn_td = {addr[63:32], addr[31:2], 2'b00}, with trn_teof_n=0.
REQ-008 trn_trem_n SHALL be 8'h00 on both beats.
REQ-009 A beat SHALL advance only when tsrc_rdy_n=0 and trn_tdst_rdy_n=0; otherwise trn_td and all control outputs hold unchanged.
REQ-010 On HDR2 acceptance:
- deassert tsrc_rdy_n, teof_n and tx_req in the next cycle;
- tag <= tag+1, modulo 2^TAG_BITS;
- addr <= addr + seg_len*4;
- segs_left <= segs_left-1;
- go to NEXT.
REQ-011 NEXT: if segs_left != 0, go to ARB (the TX interface is re-arbitrated per TLP); else go to ACK.
REQ-012 ACK: pulse read_chunk_ack for exactly 1 cycle, then return to IDLE.
REQ-013 IDLE SHALL NOT restart a fetch in the cycle immediately after the ACK pulse, because read_chunk deasserts one cycle later.
REQ-014 Latency from read_chunk rise to the first tsof_n=0 SHALL be 2 cycles when tx_grant and trn_tbuf_av[1] are already high.
REQ-015 Address arithmetic SHALL be full 64-bit with carry; wrap past 2^64 is not checked.
REQ-016 Tag SHALL wrap from 2^TAG_BITS-1 to 0 without stall.
REQ-017 MRRS changes during a chunk SHALL be ignored until the next IDLE latch.
REQ-018 tx_grant dropping in ARB SHALL keep the FSM in ARB; once a TLP has started, tx_grant SHALL be ignored until teof is accepted.

Reset
REQ-019 While reset_n=0, outputs SHALL be:
- trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n = 1;
- trn_trem_n = 8'h00;
- trn_td = 0;
- tx_req, read_chunk_ack = 0.
REQ-020 While reset_n=0, internal state SHALL be: tag=0, addr=0, FSM=IDLE.
REQ-021 Reset mid-TLP SHALL abandon the TLP immediately; no ACK is issued for the aborted chunk.

Configuration
REQ-022 Macro TX_RD_REQ_SPLIT_EN:
- defined: MRRS splitting per REQ-004.
- undefined: seg_len is fixed at 128 DW and segs_left=1, with cfg_dcommand ignored.

Verification
REQ-023 MRRS=010, addr=0x0000_0001_0000_0200, grant and buf_av high, read_chunk=1 -> TLP beats:
- HDR1 td=0x2000_0080_{id}00FF;
- HDR2 td=0x0000_0001_0000_0200;
- one ACK pulse.
REQ-024 MRRS=000, addr=0x1000 -> 4 TLPs:
- addresses 0x1000, 0x1080, 0x1100, 0x1180;
- length 0x020;
- tags 0,1,2,3;
- a single ACK after the 4th.
REQ-025 trn_tdst_rdy_n=1 for 5 cycles during HDR2 -> td, teof_n and tsrc_rdy_n held constant; exactly one TLP observed.
REQ-026 tag at 31 (TAG_BITS=5), MRRS=001 -> tags 31 then 0; addr 0xFFFF_FFFF_FFFF_FF00 wraps to 0x0.
REQ-027 reset_n=0 asserted between HDR1 and HDR2 -> all outputs at reset values the same cycle; the next chunk starts with tag 0.
REQ-028 Macro undefined, MRRS=000 -> a single 0x080-DW TLP per chunk.

Source files
------------

// File: rtl/tx_rd_req_tlp_gen.sv
// Memory-read request TLP generator: splits a 512 B chunk fetch into MRd TLPs on the TRN TX bus.
// Optional TX_RD_REQ_SPLIT_EN splits by MRRS; when undefined every chunk is one 128 DW request.
//
// state | meaning
// IDLE  | waiting for read_chunk, latches address and segment size
// ARB   | tx_req raised, waiting for grant and non-posted buffer space
// HDR1  | first header beat presented (tsof)
// HDR2  | second header beat presented (teof, address)
// NEXT  | decide whether another segment is needed
// ACK   | one-cycle read_chunk_ack
module tx_rd_req_tlp_gen #(
    parameter int TAG_BITS = 5
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic        read_chunk,
    input  logic [63:0] huge_page_addr_read_from,
    output logic        read_chunk_ack,
    output logic        tx_req,
    input  logic        tx_grant,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [3:0]  trn_tbuf_av,
    input  logic [15:0] cfg_completer_id,
    input  logic [15:0] cfg_dcommand
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        HDR1 = 3'd2,
        HDR2 = 3'd3,
        NEXT = 3'd4,
        ACK  = 3'd5
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [63:0]         addr;
    logic [9:0]          seg_len;
    logic [2:0]          segs_left;
    logic [TAG_BITS-1:0] tag;
    logic                ack_hold;

    logic [9:0]  len_lat;
    logic [2:0]  segs_lat;
    logic        beat_ok;
    logic        start;
    logic        arb_win;
    logic [7:0]  tag_ext;
    logic [63:0] hdr1;
    logic [63:0] hdr2;

    logic [63:0] td_nxt;
    logic        tsof_nxt;
    logic        teof_nxt;
    logic        rdy_nxt;
    logic        unused_bits;

    assign beat_ok = ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n;
    // ack_hold masks the cycle after ACK, while the requester still shows read_chunk high
    assign start   = (state == IDLE) & read_chunk & ~ack_hold;
    assign arb_win = (state == ARB) & tx_grant & trn_tbuf_av[1];
    assign tag_ext = 8'(tag);

    assign hdr1 = {1'b0, 7'b0100000, 1'b0, 3'b000, 4'b0, 1'b0, 1'b0, 2'b00, 2'b00, seg_len,
                   cfg_completer_id, tag_ext, 4'hF, 4'hF};
    assign hdr2 = {addr[63:2], 2'b00};

`ifdef TX_RD_REQ_SPLIT_EN
    always_comb begin
        len_lat  = 10'd128;
        segs_lat = 3'd1;
        case (cfg_dcommand[14:12])
            3'b000: begin
                len_lat  = 10'd32;
                segs_lat = 3'd4;
            end
            3'b001: begin
                len_lat  = 10'd64;
                segs_lat = 3'd2;
            end
            default: begin
                len_lat  = 10'd128;
                segs_lat = 3'd1;
            end
        endcase
    end
    assign unused_bits = ^{cfg_dcommand[15], cfg_dcommand[11:0], trn_tbuf_av[3:2], trn_tbuf_av[0]};
`else
    always_comb begin
        len_lat  = 10'd128;
        segs_lat = 3'd1;
    end
    assign unused_bits = ^{cfg_dcommand, trn_tbuf_av[3:2], trn_tbuf_av[0]};
`endif

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARB;
            ARB:     if (arb_win) state_nxt = HDR1;
            HDR1:    if (beat_ok) state_nxt = HDR2;
            HDR2:    if (beat_ok) state_nxt = NEXT;
            NEXT:    state_nxt = (segs_left != 3'd0) ? ARB : ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat outputs are registered; they only move on entry to HDR1 or on an accepted beat
    always_comb begin
        td_nxt   = trn_td;
        tsof_nxt = trn_tsof_n;
        teof_nxt = trn_teof_n;
        rdy_nxt  = trn_tsrc_rdy_n;
        case (state)
            ARB: if (arb_win) begin
                td_nxt   = hdr1;
                tsof_nxt = 1'b0;
                teof_nxt = 1'b1;
                rdy_nxt  = 1'b0;
            end
            HDR1: if (beat_ok) begin
                td_nxt   = hdr2;
                tsof_nxt = 1'b1;
                teof_nxt = 1'b0;
            end
            HDR2: if (beat_ok) begin
                teof_nxt = 1'b1;
                rdy_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            trn_td         <= 64'd0;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
        end else begin
            trn_td         <= td_nxt;
            trn_tsof_n     <= tsof_nxt;
            trn_teof_n     <= teof_nxt;
            trn_tsrc_rdy_n <= rdy_nxt;
        end
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= 64'd0;
            seg_len   <= 10'd0;
            segs_left <= 3'd0;
            tag       <= '0;
            ack_hold  <= 1'b0;
        end else begin
            ack_hold <= (state == ACK);
            if (start) begin
                addr      <= huge_page_addr_read_from;
                seg_len   <= len_lat;
                segs_left <= segs_lat;
            end else if ((state == HDR2) && beat_ok) begin
                addr      <= addr + {52'd0, seg_len, 2'b00};
                segs_left <= segs_left - 3'd1;
                tag       <= tag + TAG_BITS'(1);
            end
        end
    end

    assign tx_req         = (state == ARB) | (state == HDR1) | (state == HDR2);
    assign read_chunk_ack = (state == ACK);
    assign trn_tsrc_dsc_n = 1'b1;
    assign trn_trem_n     = 8'h00;

endmodule
